// File: rtl/layer3_result_buffer_pkg.sv
// Shared definitions for the layer-3 result buffer: word sizes, feature-map
// geometry and the pixel type moved between pooling and layer 4.
package layer3_result_buffer_pkg;

  localparam int WORDLENGTH           = 16;
  localparam int LAYER3_OUTPUT_LENGTH = 128;
  localparam int LAYER3_OUT_WIDTH     = 14;

  typedef logic [LAYER3_OUTPUT_LENGTH-1:0] pixel_t;

  // True when both coordinates fall inside a side x side feature map.
  function automatic logic in_range(input logic [15:0] row,
                                    input logic [15:0] col,
                                    input int          side);
    return (row < 16'(side)) && (col < 16'(side));
  endfunction

endpackage

// File: rtl/layer3_result_mem.sv
// Pixel storage for the layer-3 result buffer: one synchronous write port
// and one registered read port that can be forced to load zero.
module layer3_result_mem
  import layer3_result_buffer_pkg::*;
#(
  parameter int DEPTH  = 196,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [DEPTH];

  // NOTE: the array has no reset so it maps onto plain RAM; only the
  // read register below is cleared by rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/layer3_result_buffer.sv
// Layer-3 result buffer: collects pooled pixels during FILL, announces a full
// buffer with pixel_store_done, and serves layer-4 reads while READY.
module layer3_result_buffer
  import layer3_result_buffer_pkg::*;
#(
  parameter int OUT_WIDTH = LAYER3_OUT_WIDTH,
  parameter int DEPTH     = OUT_WIDTH * OUT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         save_enable,
  input  logic [15:0]  output_row,
  input  logic [15:0]  output_col,
  input  pixel_t       output_data,
  input  logic         layer3_calculation_done,
  input  logic         read_pixel_signal,
  input  logic [15:0]  read_row_addr,
  input  logic [15:0]  read_col_addr,
  input  logic         layer4_calculation_done,
  output logic         pixel_store_done,
  output pixel_t       read_data,
  output logic [7:0]   write_count,
  output logic         count_error
);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_d;
  logic       err_d, done_d;

  logic       wr_in_range, rd_in_range, wr_accept;
  logic [7:0] wr_addr, rd_addr;

  assign wr_in_range = in_range(output_row, output_col, OUT_WIDTH);
  assign rd_in_range = in_range(read_row_addr, read_col_addr, OUT_WIDTH);
  // Addresses are only used when in range, so the low byte of each
  // coordinate is sufficient.
  assign wr_addr     = output_row[7:0] * 8'(OUT_WIDTH) + output_col[7:0];
  assign rd_addr     = read_row_addr[7:0] * 8'(OUT_WIDTH) + read_col_addr[7:0];
  assign wr_accept   = save_enable && wr_in_range && (state_q != READY);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = write_count;
    err_d   = count_error;
    done_d  = 1'b0;

    if (wr_accept && write_count != 8'hFF) count_d = write_count + 8'd1;
    if (save_enable && !wr_accept)         err_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (layer3_calculation_done) state_d = READY;
        else if (save_enable)        state_d = FILL;
      end
      FILL: begin
        if (layer3_calculation_done) state_d = READY;
      end
      READY: begin
        if (layer4_calculation_done) begin
          state_d = IDLE;
          count_d = 8'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering READY: announce the buffer and audit the final fill count.
    if (state_d == READY && state_q != READY) begin
      done_d = 1'b1;
      if (count_d != 8'(DEPTH)) err_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      write_count      <= 8'd0;
      count_error      <= 1'b0;
      pixel_store_done <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_count      <= count_d;
      count_error      <= err_d;
      pixel_store_done <= done_d;
    end
  end

  layer3_result_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (8)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (output_data),
    .rd_en   (read_pixel_signal),
    .rd_zero ((state_q != READY) || !rd_in_range),
    .rd_addr (rd_addr),
    .rd_data (read_data)
  );

endmodule
